// File: rtl/dual_port_track_ram.sv
// True dual-port read-first RAM with per-port byte-lane enables on a single clock.
// Used as the floppy track buffer: port A is the SD-card DMA side and port B is the disk-controller side.
module dual_port_track_ram #(
    parameter int  DATA_WIDTH = 8,
    parameter int  ADDR_WIDTH = 13,
    localparam int BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    input  logic [BE_WIDTH-1:0]   byteena_a,
    input  logic                  enable_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    input  logic [BE_WIDTH-1:0]   byteena_b,
    input  logic                  enable_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // NOTE: the storage array has no reset; the power-up image is all zeros
    // and reset only clears the output registers.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] mask_a, mask_b;
    logic [DATA_WIDTH-1:0] wdata_a, wdata_b, base_b;
    logic                  we_a, we_b;
    logic [DATA_WIDTH-1:0] q_a_d, q_a_q, q_b_d, q_b_q;

    // Expand lane enables to bit masks; the top lane is clipped by DATA_WIDTH.
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            mask_a[j] = byteena_a[j/8];
            mask_b[j] = byteena_b[j/8];
        end
    end

    // On a same-address collision, B merges on top of A's word so that
    // A-only lanes survive and lanes shared by both ports take B's data.
    always_comb begin
        we_a    = enable_a && wren_a;
        we_b    = enable_b && wren_b;
        wdata_a = (mem[address_a] & ~mask_a) | (data_a & mask_a);
        base_b  = (we_a && (address_a == address_b)) ? wdata_a : mem[address_b];
        wdata_b = (base_b & ~mask_b) | (data_b & mask_b);
    end

    // NOTE: non-blocking writes let the read path below see the pre-edge
    // contents, which is what makes both ports read-first.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[address_a] <= wdata_a;
        end
        if (we_b) begin
            mem[address_b] <= wdata_b;
        end
    end

    always_comb begin
        q_a_d = q_a_q;
        q_b_d = q_b_q;
        if (reset) begin
            q_a_d = '0;
            q_b_d = '0;
        end else begin
            if (enable_a) begin
                q_a_d = mem[address_a];
            end
            if (enable_b) begin
                q_b_d = mem[address_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        q_a_q <= q_a_d;
        q_b_q <= q_b_d;
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_track_ram.sv
// Bench for dual_port_track_ram: a directed vector table on the default 8x13 instance, a 16-bit lane sequence,
// then random traffic on both instances checked against an array model.
module tb_dual_port_track_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [12:0] aa8, ab8;
    logic [7:0]  da8, db8, qa8, qb8;
    logic        wa8, wb8, ea8, eb8;
    logic [0:0]  bea8, beb8;

    logic [5:0]  aa16, ab16;
    logic [15:0] da16, db16, qa16, qb16;
    logic        wa16, wb16, ea16, eb16;
    logic [1:0]  bea16, beb16;

    dual_port_track_ram dut8 (
        .clk(clk), .reset(reset),
        .address_a(aa8), .data_a(da8), .wren_a(wa8), .byteena_a(bea8), .enable_a(ea8), .q_a(qa8),
        .address_b(ab8), .data_b(db8), .wren_b(wb8), .byteena_b(beb8), .enable_b(eb8), .q_b(qb8)
    );

    dual_port_track_ram #(16, 6) dut16 (
        .clk(clk), .reset(reset),
        .address_a(aa16), .data_a(da16), .wren_a(wa16), .byteena_a(bea16), .enable_a(ea16), .q_a(qa16),
        .address_b(ab16), .data_b(db16), .wren_b(wb16), .byteena_b(beb16), .enable_b(eb16), .q_b(qb16)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus the expected output registers.
    logic [7:0]  m8  [8192];
    logic [15:0] m16 [64];
    logic [7:0]  mqa8, mqb8;
    logic [15:0] mqa16, mqb16;

    typedef struct {
        logic        rst;
        logic        ea, wa;
        logic [12:0] aa;
        logic [7:0]  da;
        logic        bea;
        logic        eb, wb;
        logic [12:0] ab;
        logic [7:0]  db;
        logic        beb;
        logic [7:0]  xa, xb;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // One rising edge, with the model applying the documented rules: reads see
    // old contents, then A writes, then B writes (so B wins shared lanes).
    task automatic step();
        @(posedge clk);
        if (reset) begin
            mqa8 = '0; mqb8 = '0; mqa16 = '0; mqb16 = '0;
        end else begin
            if (ea8)  mqa8  = m8[aa8];
            if (eb8)  mqb8  = m8[ab8];
            if (ea16) mqa16 = m16[aa16];
            if (eb16) mqb16 = m16[ab16];
        end
        if (ea8 && wa8)   m8[aa8]   = 8'(merge({8'h0, m8[aa8]}, {8'h0, da8}, {1'b0, bea8}));
        if (eb8 && wb8)   m8[ab8]   = 8'(merge({8'h0, m8[ab8]}, {8'h0, db8}, {1'b0, beb8}));
        if (ea16 && wa16) m16[aa16] = merge(m16[aa16], da16, bea16);
        if (eb16 && wb16) m16[ab16] = merge(m16[ab16], db16, beb16);
        @(negedge clk);
    endtask

    task automatic idle();
        ea8 = 0; wa8 = 0; aa8 = '0; da8 = '0; bea8 = '0;
        eb8 = 0; wb8 = 0; ab8 = '0; db8 = '0; beb8 = '0;
        ea16 = 0; wa16 = 0; aa16 = '0; da16 = '0; bea16 = '0;
        eb16 = 0; wb16 = 0; ab16 = '0; db16 = '0; beb16 = '0;
    endtask

    task automatic set16(input logic ea, input logic wa, input logic [5:0] aa, input logic [15:0] da,
                         input logic [1:0] bea, input logic eb, input logic wb, input logic [5:0] ab,
                         input logic [15:0] db, input logic [1:0] beb);
        ea16 = ea; wa16 = wa; aa16 = aa; da16 = da; bea16 = bea;
        eb16 = eb; wb16 = wb; ab16 = ab; db16 = db; beb16 = beb;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) m8[i] = '0;
        for (int i = 0; i < 64; i++) m16[i] = '0;
        mqa8 = '0; mqb8 = '0; mqa16 = '0; mqb16 = '0;

        //          rst ea wa aa        da     bea eb wb ab        db     beb xa     xb
        tbl[0]  = '{0, 1, 1, 13'h0123, 8'h5A, 1, 0, 0, 13'h0000, 8'h00, 0, 8'h00, 8'h00};
        tbl[1]  = '{0, 1, 0, 13'h1FFF, 8'h00, 0, 1, 0, 13'h0123, 8'h00, 0, 8'h00, 8'h5A};
        tbl[2]  = '{0, 1, 1, 13'h0010, 8'h11, 1, 0, 0, 13'h0000, 8'h00, 0, 8'h00, 8'h5A};
        tbl[3]  = '{0, 1, 1, 13'h0010, 8'hC3, 1, 0, 0, 13'h0000, 8'h00, 0, 8'h11, 8'h5A};
        tbl[4]  = '{0, 1, 0, 13'h0010, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 8'hC3, 8'h5A};
        tbl[5]  = '{0, 0, 0, 13'h0000, 8'h00, 0, 1, 1, 13'h0010, 8'h11, 1, 8'hC3, 8'hC3};
        tbl[6]  = '{0, 1, 1, 13'h0010, 8'hC3, 1, 1, 0, 13'h0010, 8'h00, 0, 8'h11, 8'h11};
        tbl[7]  = '{0, 0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h0010, 8'h00, 0, 8'h11, 8'hC3};
        tbl[8]  = '{0, 1, 1, 13'h0200, 8'hAA, 1, 1, 1, 13'h0200, 8'h55, 1, 8'h00, 8'h00};
        tbl[9]  = '{0, 1, 0, 13'h0200, 8'h00, 0, 1, 0, 13'h0200, 8'h00, 0, 8'h55, 8'h55};
        tbl[10] = '{0, 0, 0, 13'h0000, 8'h00, 0, 0, 1, 13'h0300, 8'h77, 1, 8'h55, 8'h55};
        tbl[11] = '{0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0300, 8'h00, 0, 8'h00, 8'h00};
        tbl[12] = '{0, 1, 1, 13'h0201, 8'hAA, 1, 1, 1, 13'h0201, 8'h55, 0, 8'h00, 8'h00};
        tbl[13] = '{0, 1, 0, 13'h0201, 8'h00, 0, 1, 0, 13'h0201, 8'h00, 0, 8'hAA, 8'hAA};
        tbl[14] = '{0, 1, 0, 13'h0123, 8'h00, 0, 1, 0, 13'h0201, 8'h00, 0, 8'h5A, 8'hAA};
        tbl[15] = '{1, 1, 0, 13'h0123, 8'h00, 0, 1, 1, 13'h0400, 8'h99, 1, 8'h00, 8'h00};
        tbl[16] = '{1, 1, 0, 13'h0123, 8'h00, 0, 1, 1, 13'h0400, 8'h99, 1, 8'h00, 8'h00};
        tbl[17] = '{0, 0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 8'h00, 8'h00};
        tbl[18] = '{0, 1, 0, 13'h0123, 8'h00, 0, 1, 0, 13'h0400, 8'h00, 0, 8'h5A, 8'h99};
        tbl[19] = '{0, 1, 1, 13'h1FFF, 8'hFF, 1, 1, 0, 13'h0000, 8'h00, 0, 8'h00, 8'h00};
        tbl[20] = '{0, 1, 0, 13'h1FFF, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 0, 8'hFF, 8'h00};

        // Reset state.
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        check("reset qa8", {8'h0, qa8}, 16'h0);
        check("reset qb8", {8'h0, qb8}, 16'h0);
        check("reset qa16", qa16, 16'h0);
        check("reset qb16", qb16, 16'h0);
        reset = 1'b0;

        // Directed table on the 8-bit instance.
        for (int i = 0; i < 21; i++) begin
            reset = tbl[i].rst;
            ea8 = tbl[i].ea; wa8 = tbl[i].wa; aa8 = tbl[i].aa; da8 = tbl[i].da; bea8 = tbl[i].bea;
            eb8 = tbl[i].eb; wb8 = tbl[i].wb; ab8 = tbl[i].ab; db8 = tbl[i].db; beb8 = tbl[i].beb;
            step();
            check($sformatf("vec%0d qa", i), {8'h0, qa8}, {8'h0, tbl[i].xa});
            check($sformatf("vec%0d qb", i), {8'h0, qb8}, {8'h0, tbl[i].xb});
        end
        idle();
        reset = 1'b0;

        // Byte lanes and partial-lane collisions on the 16-bit instance.
        set16(1, 1, 6'd5, 16'h1234, 2'b11, 0, 0, 6'd0, 16'h0, 2'b00); step();
        check("be16 first", qa16, 16'h0000);
        set16(1, 1, 6'd5, 16'hABCD, 2'b10, 0, 0, 6'd0, 16'h0, 2'b00); step();
        check("be16 read-first", qa16, 16'h1234);
        set16(1, 1, 6'd5, 16'hFFEE, 2'b00, 0, 0, 6'd0, 16'h0, 2'b00); step();
        check("be16 upper lane", qa16, 16'hAB34);
        set16(1, 0, 6'd5, 16'h0000, 2'b00, 1, 0, 6'd5, 16'h0, 2'b00); step();
        check("be16 no lanes a", qa16, 16'hAB34);
        check("be16 no lanes b", qb16, 16'hAB34);
        set16(1, 1, 6'd7, 16'h1111, 2'b01, 1, 1, 6'd7, 16'h2222, 2'b10); step();
        set16(1, 1, 6'd7, 16'h3333, 2'b11, 1, 1, 6'd7, 16'h4444, 2'b01); step();
        check("coll16 disjoint a", qa16, 16'h2211);
        check("coll16 disjoint b", qb16, 16'h2211);
        set16(1, 0, 6'd7, 16'h0000, 2'b00, 1, 0, 6'd7, 16'h0, 2'b00); step();
        check("coll16 overlap a", qa16, 16'h3344);
        check("coll16 overlap b", qb16, 16'h3344);
        idle();

        // Random traffic on both instances against the model; addresses are
        // clustered so collisions and read-after-write happen often.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 31) == 0);
            ea8 = 1'($urandom); wa8 = 1'($urandom); da8 = 8'($urandom); bea8 = 1'($urandom);
            eb8 = 1'($urandom); wb8 = 1'($urandom); db8 = 8'($urandom); beb8 = 1'($urandom);
            aa8 = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7));
            ab8 = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7));
            ea16 = 1'($urandom); wa16 = 1'($urandom); da16 = 16'($urandom); bea16 = 2'($urandom);
            eb16 = 1'($urandom); wb16 = 1'($urandom); db16 = 16'($urandom); beb16 = 2'($urandom);
            aa16 = 6'($urandom_range(0, 3));
            ab16 = 6'($urandom_range(0, 3));
            step();
            check("rand qa8", {8'h0, qa8}, {8'h0, mqa8});
            check("rand qb8", {8'h0, qb8}, {8'h0, mqb8});
            check("rand qa16", qa16, mqa16);
            check("rand qb16", qb16, mqb16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_track_ram.md
# dual_port_track_ram

True dual-port synchronous RAM with independent read/write ports A and B and per-port byte-lane enables. Both ports run on one clock. It is the 13-bit × 8-bit floppy track buffer: port A is the SD-card DMA side, and port B is the disk-controller side. It is parameterised so the same block serves other buffers.

## Interface
Parameters:
- DATA_WIDTH, default 8: word width in bits (first positional parameter).
- ADDR_WIDTH, default 13: address width; depth = 2**ADDR_WIDTH words (second positional parameter).
- BE_WIDTH, derived, not overridable: (DATA_WIDTH+7)/8, the number of byte lanes. The top lane may be partial.

Ports:
- clk  in  1  clock for both ports; all activity on rising edge.
- reset  in  1  synchronous, active-high.
- address_a  in  ADDR_WIDTH  port A word address.
- data_a  in  DATA_WIDTH  port A write data.
- wren_a  in  1  port A write request.
- byteena_a  in  BE_WIDTH  port A lane mask; lane i covers bits [8i+7:8i], clipped to DATA_WIDTH.
- enable_a  in  1  port A clock enable.
- q_a  out  DATA_WIDTH  port A registered read data.
- address_b, data_b, wren_b, byteena_b, enable_b, q_b: port B equivalents, same widths and meanings.

## Operation
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits. Contents initialise to all zeros at time 0. Reset never clears memory.
- Write on port X at a rising edge requires enable_X=1 and wren_X=1.
  - Only lanes with byteena_X[i]=1 are updated.
  - Other lanes keep their contents.
  - Writes are performed regardless of reset.
- Read on port X at a rising edge with enable_X=1 and reset=0: q_X <= mem[address_X], as the value before any write in the same edge (read-first).
  - Applies to a same-port write: q_X shows old data, not data_X.
  - Applies to a cross-port write to the same address: also old data.
- enable_X=0: no read or write on port X; q_X holds its value.
- Collision: both ports write the same address in the same edge.
  - For lanes enabled on both ports, port B data wins.
  - Lanes enabled on only one port take that port's data.
- reset=1 at a rising edge: q_a and q_b <= 0, overriding any read. Memory is not altered except by writes in that cycle.
- Addresses are fully decoded; there is no wrap or out-of-range case.
- No state machine; purely per-edge behaviour.

## Timing
- Read latency 1 cycle: address sampled at edge N, data valid on q_X after edge N and held until the next enabled read or reset.
- Write latency: data written at edge N is visible to a read sampled at edge N+1 on either port.
- Reset values: q_a=0, q_b=0. They stay 0 while reset is held and remain 0 after release until the first enabled read.
- Outputs are fully registered; no combinational path from any input to q_a or q_b.
- Ports are independent: a read on A and a write on B (different addresses) complete in the same edge without stall.

## Test plan
- Basic write/read, defaults (8,13): A writes 0x5A at 0x0123 (byteena=1). At the next edge B reads 0x0123 -> q_b=0x5A one cycle later. A reads 0x1FFF -> 0x00 (power-up zero).
- Read-first: A writes 0xC3 to 0x0010, which holds 0x11, while simultaneously reading 0x0010 -> q_a=0x11. The next read -> 0xC3. Same test with B reading 0x0010 in the write edge -> q_b=0x11.
- Collision: A writes 0xAA and B writes 0x55 to 0x0200 in the same edge -> the following read returns 0x55.
- Byte enables (DATA_WIDTH=16): word holds 0x1234. Write 0xABCD with byteena=2'b10 -> 0xAB34. Write 0xFFEE with byteena=2'b00 -> unchanged 0xAB34.
- Enable gating: enable_b=0 with wren_b=1, data 0x77 at 0x0300 -> memory unchanged, q_b holds its prior value. Re-enable and read -> old contents.
- Reset: q_a=0x5A, then reset=1 for 2 cycles while A reads 0x0123 and B writes 0x99 to 0x0400 -> q_a=q_b=0 during reset. After release, reading 0x0400 -> 0x99 and reading 0x0123 -> 0x5A (memory preserved).
